// File: rtl/fir_stream_pkg.sv
// Shared definitions for the FIR post-processing chain: default widths, the
// stage FSM encoding and the rounding/saturation helper used by several stages.
package fir_stream_pkg;

    localparam int FIR_DATA_W = 32;
    localparam int FIR_OUT_W  = 16;

    typedef enum logic [0:0] {
        ST_WARMUP = 1'b0,
        ST_RUN    = 1'b1
    } fsm_state_e;

    // Round half up, arithmetic shift right, then clamp to a signed out_w range.
    // Works at 64 bits so any input up to 62 bits gets its extra carry bit for free.
    function automatic logic signed [63:0] round_sat(
        input logic signed [63:0] x,
        input int                 shift,
        input int                 out_w
    );
        logic signed [63:0] sum;
        logic signed [63:0] y;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sum = x;
        if (shift > 0) begin
            sum = x + (64'sd1 <<< (shift - 1));
        end
        y  = sum >>> shift;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (y > hi) begin
            round_sat = hi;
        end else if (y < lo) begin
            round_sat = lo;
        end else begin
            round_sat = y;
        end
    endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry ready/valid buffer: an output register backed by one skid register.
// Handshake: a beat moves when valid && ready; valid never waits on ready, and
// out_data/out_last hold steady while out_valid && !out_ready.
module stream_skid_buf #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_valid,
    input  logic [W-1:0] push_data,
    input  logic         push_last,
    output logic         push_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last
);

    logic         skid_valid;
    logic [W-1:0] skid_data;
    logic         skid_last;
    logic         drain;
    logic         push_ok;

    // Readiness depends only on the skid flop, so it never sees out_ready combinationally.
    assign push_ready = !skid_valid;
    assign push_ok    = push_valid && !skid_valid;
    assign drain      = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_last  <= 1'b0;
        end else if (drain || !out_valid) begin
            // Output slot frees up: the older skid entry always goes first.
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_data   <= skid_data;
                out_last   <= skid_last;
                skid_valid <= 1'b0;
            end else if (push_ok) begin
                out_valid <= 1'b1;
                out_data  <= push_data;
                out_last  <= push_last;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (push_ok) begin
            skid_valid <= 1'b1;
            skid_data  <= push_data;
            skid_last  <= push_last;
        end
    end

endmodule

// File: rtl/fir_decimate_stage.sv
// Drops the FIR fill samples, keeps one in DECIM of the rest, rescales each kept
// sample to OUT_W bits and streams it out with a frame-end marker.
module fir_decimate_stage
    import fir_stream_pkg::*;
#(
    parameter int DATA_W    = FIR_DATA_W,
    parameter int OUT_W     = FIR_OUT_W,
    parameter int SKIP      = 15,
    parameter int DECIM     = 4,
    parameter int SHIFT     = 4,
    parameter int FRAME_LEN = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_last,
    output fsm_state_e        state_dbg
);

    localparam int SKIP_W  = (SKIP > 1) ? $clog2(SKIP) : 1;
    localparam int PHASE_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int FRAME_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    localparam logic [SKIP_W-1:0]  SKIP_LAST  = SKIP_W'((SKIP > 0) ? SKIP - 1 : 0);
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(DECIM - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAME_LEN - 1);
    localparam logic [FRAME_W:0]   FRAME_SPAN = (FRAME_W + 1)'(FRAME_LEN);
    localparam fsm_state_e         STATE_RST  = (SKIP == 0) ? ST_RUN : ST_WARMUP;

    fsm_state_e         state_q, state_d;
    logic [SKIP_W-1:0]  skip_cnt, skip_cnt_d;
    logic [PHASE_W-1:0] phase, phase_d;
    logic [FRAME_W-1:0] frame_cnt, frame_cnt_d;
    logic [FRAME_W:0]   tag_idx;

    logic              buf_ready;
    logic              xfer;
    logic              keep;
    logic              push_last;
    logic [OUT_W-1:0]  push_data;

    assign in_ready  = buf_ready && !reset;
    assign xfer      = in_valid && in_ready;
    assign keep      = xfer && (state_q == ST_RUN) && (phase == '0);
    assign state_dbg = state_q;
    assign push_data = OUT_W'(round_sat(64'(signed'(in_data)), SHIFT, OUT_W));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= STATE_RST;
            skip_cnt  <= '0;
            phase     <= '0;
            frame_cnt <= '0;
        end else begin
            state_q   <= state_d;
            skip_cnt  <= skip_cnt_d;
            phase     <= phase_d;
            frame_cnt <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        skip_cnt_d = skip_cnt;
        phase_d    = phase;
        case (state_q)
            ST_WARMUP: begin
                if (xfer) begin
                    if (skip_cnt == SKIP_LAST) begin
                        state_d    = ST_RUN;
                        skip_cnt_d = '0;
                    end else begin
                        skip_cnt_d = skip_cnt + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (xfer) begin
                    phase_d = (phase == PHASE_LAST) ? '0 : phase + 1'b1;
                end
            end
            default: state_d = STATE_RST;
        endcase
    end

    // frame_cnt indexes the sample on the output register. A push can only happen
    // with the skid empty, so the new sample sits exactly out_valid places behind it.
    always_comb begin
        frame_cnt_d = frame_cnt;
        if (out_valid && out_ready) begin
            frame_cnt_d = (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + 1'b1;
        end
        tag_idx = {1'b0, frame_cnt} + {{FRAME_W{1'b0}}, out_valid};
        if (tag_idx > {1'b0, FRAME_LAST}) begin
            tag_idx = tag_idx - FRAME_SPAN;
        end
        push_last = (tag_idx[FRAME_W-1:0] == FRAME_LAST);
    end

    stream_skid_buf #(
        .W(OUT_W)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .push_valid(keep),
        .push_data (push_data),
        .push_last (push_last),
        .push_ready(buf_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

endmodule

// File: tb/tb_fir_decimate_stage.sv
// Directed bench for fir_decimate_stage: three instances cover the default
// configuration, SKIP=0/DECIM=1, and FRAME_LEN=4/SKIP=0/DECIM=2.
module tb_fir_decimate_stage;
    import fir_stream_pkg::*;

    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    logic [15:0] exp_q[$];
    logic        exp_last_q[$];

    // Instance A: default parameters
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
    logic [31:0] a_in_data;
    logic [15:0] a_out_data;
    fsm_state_e  a_state;
    // Instance B: SKIP=0, DECIM=1
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
    logic [31:0] b_in_data;
    logic [15:0] b_out_data;
    fsm_state_e  b_state;
    // Instance C: FRAME_LEN=4, SKIP=0, DECIM=2
    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_last;
    logic [31:0] c_in_data;
    logic [15:0] c_out_data;
    fsm_state_e  c_state;

    fir_decimate_stage dut_a (
        .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_last(a_out_last), .state_dbg(a_state)
    );

    fir_decimate_stage #(.SKIP(0), .DECIM(1)) dut_b (
        .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_last(b_out_last), .state_dbg(b_state)
    );

    fir_decimate_stage #(.SKIP(0), .DECIM(2), .FRAME_LEN(4)) dut_c (
        .clk(clk), .reset(reset), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_data(c_out_data), .out_last(c_out_last), .state_dbg(c_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        a_in_valid = 0; a_in_data = '0; a_out_ready = 0;
        b_in_valid = 0; b_in_data = '0; b_out_ready = 0;
        c_in_valid = 0; c_in_data = '0; c_out_ready = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        idle_inputs();
        repeat (2) @(negedge clk);
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        idle_inputs();
        repeat (2) @(negedge clk);
        checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready_low: got %b expected 0", a_in_ready); end
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", a_out_valid); end
        checks++; if (a_out_data !== 16'd0) begin failures++; $display("FAIL reset_out_data: got %0d expected 0", a_out_data); end
        checks++; if (a_out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last: got %b expected 0", a_out_last); end
        checks++; if (a_state !== ST_WARMUP) begin failures++; $display("FAIL reset_state_warmup: got %0d expected %0d", a_state, ST_WARMUP); end
        checks++; if (b_state !== ST_RUN) begin failures++; $display("FAIL reset_state_run_skip0: got %0d expected %0d", b_state, ST_RUN); end
        reset = 0;
        @(negedge clk);
        checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready_high: got %b expected 1", a_in_ready); end
        checks++; if (c_in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready_high_c: got %b expected 1", c_in_ready); end
    endtask

    // 15 zeros then 1360 + 120*k; kept outputs are 85 + 30*j
    task automatic test_golden();
        int n_in = 0;
        int n_out = 0;
        int t16 = -10;
        logic [15:0] exp;
        do_reset();
        a_out_ready = 1;
        for (int cyc = 0; cyc < 200 && n_out < 8; cyc++) begin
            @(negedge clk);
            if (a_out_valid) begin
                if (n_out == 0) begin
                    checks++;
                    if (cyc != t16 + 1) begin failures++; $display("FAIL golden_latency: got cycle %0d expected %0d", cyc, t16 + 1); end
                end
                exp = 16'(85 + 30 * n_out);
                checks++;
                if (a_out_data !== exp) begin failures++; $display("FAIL golden_data[%0d]: got %0d expected %0d", n_out, a_out_data, exp); end
                n_out++;
            end
            if (n_in < 44) begin
                a_in_valid = 1;
                a_in_data  = (n_in < 15) ? 32'd0 : 32'(1360 + 120 * (n_in - 15));
                if (a_in_ready) begin
                    if (n_in == 15) t16 = cyc;
                    n_in++;
                end
            end else begin
                a_in_valid = 0;
            end
        end
        a_in_valid = 0;
        checks++; if (n_out != 8) begin failures++; $display("FAIL golden_count: got %0d expected 8", n_out); end
    endtask

    task automatic test_saturation();
        logic [31:0] vin[6];
        logic [15:0] vexp[6];
        int n_in = 0;
        int n_out = 0;
        vin  = '{32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFE8, 32'hFFFFFFE7, 32'd8, 32'd7};
        vexp = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'hFFFE, 16'd1, 16'd0};
        do_reset();
        b_out_ready = 1;
        for (int cyc = 0; cyc < 50 && n_out < 6; cyc++) begin
            @(negedge clk);
            if (b_out_valid) begin
                checks++;
                if (b_out_data !== vexp[n_out]) begin failures++; $display("FAIL sat_data[%0d]: got %0d expected %0d", n_out, $signed(b_out_data), $signed(vexp[n_out])); end
                n_out++;
            end
            if (n_in < 6) begin
                b_in_valid = 1;
                b_in_data  = vin[n_in];
                if (b_in_ready) n_in++;
            end else begin
                b_in_valid = 0;
            end
        end
        b_in_valid = 0;
        checks++; if (n_out != 6) begin failures++; $display("FAIL sat_count: got %0d expected 6", n_out); end
    endtask

    // DECIM=1, SKIP=0: inputs 16*k map to k, one per cycle once started
    task automatic test_full_throughput();
        int n_in = 0;
        int n_out = 0;
        do_reset();
        b_out_ready = 1;
        for (int cyc = 0; cyc < 100 && n_out < 20; cyc++) begin
            @(negedge clk);
            if (n_out > 0) begin
                checks++;
                if (b_out_valid !== 1'b1) begin failures++; $display("FAIL throughput_bubble: got out_valid %b expected 1 at output %0d", b_out_valid, n_out); end
            end
            if (b_out_valid) begin
                checks++;
                if (b_out_data !== 16'(n_out)) begin failures++; $display("FAIL throughput_data[%0d]: got %0d expected %0d", n_out, b_out_data, n_out); end
                n_out++;
            end
            if (n_in < 20) begin
                b_in_valid = 1;
                b_in_data  = 32'(16 * n_in);
                if (b_in_ready) n_in++;
            end else begin
                b_in_valid = 0;
            end
        end
        b_in_valid = 0;
        checks++; if (n_out != 20) begin failures++; $display("FAIL throughput_count: got %0d expected 20", n_out); end
    endtask

    // Inputs 0..31, kept 0,2,..,30; (x+8)>>4; last on outputs 3,7,11,15
    task automatic test_frame_markers();
        int n_in = 0;
        int n_out = 0;
        logic [15:0] exp;
        logic        exp_last;
        do_reset();
        exp_q.delete();
        exp_last_q.delete();
        for (int k = 0; k < 16; k++) begin
            exp_q.push_back(16'((2 * k + 8) >> 4));
            exp_last_q.push_back((k % 4) == 3);
        end
        for (int cyc = 0; cyc < 400 && exp_q.size() > 0; cyc++) begin
            @(negedge clk);
            c_out_ready = 1'($urandom_range(0, 1));
            if (c_out_valid && c_out_ready) begin
                exp      = exp_q.pop_front();
                exp_last = exp_last_q.pop_front();
                checks++;
                if (c_out_data !== exp) begin failures++; $display("FAIL frame_data[%0d]: got %0d expected %0d", n_out, c_out_data, exp); end
                checks++;
                if (c_out_last !== exp_last) begin failures++; $display("FAIL frame_last[%0d]: got %b expected %b", n_out, c_out_last, exp_last); end
                n_out++;
            end
            if (n_in < 32) begin
                c_in_valid = 1;
                c_in_data  = 32'(n_in);
                if (c_in_ready) n_in++;
            end else begin
                c_in_valid = 0;
            end
        end
        c_in_valid = 0;
        c_out_ready = 0;
        checks++; if (n_out != 16) begin failures++; $display("FAIL frame_count: got %0d expected 16", n_out); end
    endtask

    task automatic test_back_pressure();
        int n_in = 0;
        int occ = 0;
        int n_out = 0;
        logic        prev_stall = 0;
        logic [15:0] prev_data = '0;
        logic        prev_last = 0;
        logic [15:0] exp;
        do_reset();
        exp_q.delete();
        for (int cyc = 0; cyc < 40000 && (n_in < 4096 || exp_q.size() > 0); cyc++) begin
            @(negedge clk);
            checks++;
            if (a_in_ready !== (occ < 2)) begin failures++; $display("FAIL bp_in_ready: got %b expected %b (occupancy %0d)", a_in_ready, (occ < 2), occ); end
            checks++;
            if (a_out_valid !== (occ > 0)) begin failures++; $display("FAIL bp_out_valid: got %b expected %b (occupancy %0d)", a_out_valid, (occ > 0), occ); end
            if (prev_stall) begin
                checks++;
                if (a_out_data !== prev_data || a_out_last !== prev_last) begin
                    failures++; $display("FAIL bp_stall_stable: got %0d/%b expected %0d/%b", a_out_data, a_out_last, prev_data, prev_last);
                end
            end
            a_out_ready = 1'($urandom_range(0, 1));
            if (a_out_valid && a_out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL bp_extra_output: got %0d expected no output", a_out_data);
                end else begin
                    exp = exp_q.pop_front();
                    if (a_out_data !== exp) begin failures++; $display("FAIL bp_data[%0d]: got %0d expected %0d", n_out, a_out_data, exp); end
                end
                n_out++;
                occ--;
            end
            prev_stall = a_out_valid && !a_out_ready;
            prev_data  = a_out_data;
            prev_last  = a_out_last;
            if (n_in < 4096 && $urandom_range(0, 1) == 1) begin
                a_in_valid = 1;
                a_in_data  = (n_in < 15) ? 32'd0 : 32'(1360 + 120 * (n_in - 15));
                if (a_in_ready) begin
                    if (n_in >= 15 && ((n_in - 15) % 4) == 0) begin
                        exp_q.push_back(16'(85 + 30 * ((n_in - 15) / 4)));
                        occ++;
                    end
                    n_in++;
                end
            end else begin
                a_in_valid = 0;
            end
        end
        a_in_valid = 0;
        a_out_ready = 0;
        checks++; if (n_out != 1021) begin failures++; $display("FAIL bp_count: got %0d expected 1021", n_out); end
    endtask

    task automatic test_reset_mid_stream();
        int n_in = 0;
        int n_out = 0;
        int t16 = -10;
        do_reset();
        a_out_ready = 1;
        for (int cyc = 0; cyc < 100 && n_in < 40; cyc++) begin
            @(negedge clk);
            a_in_valid = 1;
            a_in_data  = 32'd0;
            if (a_in_ready) n_in++;
        end
        @(negedge clk);
        checks++; if (a_out_valid !== 1'b1) begin failures++; $display("FAIL rst_mid_pending: got %b expected 1", a_out_valid); end
        a_in_valid  = 0;
        a_out_ready = 0;
        reset = 1;
        @(negedge clk);
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_flush: got %b expected 0", a_out_valid); end
        checks++; if (a_state !== ST_WARMUP) begin failures++; $display("FAIL rst_mid_state: got %0d expected %0d", a_state, ST_WARMUP); end
        reset = 0;
        a_out_ready = 1;
        n_in = 0;
        for (int cyc = 0; cyc < 100 && n_out < 1; cyc++) begin
            @(negedge clk);
            if (a_out_valid) begin
                checks++;
                if (cyc != t16 + 1) begin failures++; $display("FAIL rst_mid_latency: got cycle %0d expected %0d", cyc, t16 + 1); end
                checks++;
                if (a_out_data !== 16'd160) begin failures++; $display("FAIL rst_mid_data: got %0d expected 160", a_out_data); end
                n_out++;
            end
            if (n_in < 16) begin
                a_in_valid = 1;
                a_in_data  = 32'(160 * (n_in + 1));
                if (a_in_ready) begin
                    if (n_in == 15) t16 = cyc;
                    n_in++;
                end
            end else begin
                a_in_valid = 0;
            end
        end
        a_in_valid = 0;
        checks++; if (n_out != 1) begin failures++; $display("FAIL rst_mid_count: got %0d expected 1", n_out); end
    endtask

    initial begin
        test_reset();
        test_golden();
        test_saturation();
        test_full_throughput();
        test_frame_markers();
        test_back_pressure();
        test_reset_mid_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
